// File: rtl/lfsr_rr_sched_pkg.sv
// lfsr_rr_sched_pkg: shared types and constants for the LFSR round-robin scheduler
package lfsr_rr_sched_pkg;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LOCKUP = 8'hFF;
    localparam logic [LFSR_W-1:0] DEF_SEED = 8'hA5;
    typedef enum logic [1:0] {SEED, IDLE, STEP, DELIVER} state_t;
    // An all-ones seed would freeze an XNOR LFSR, so substitute the default
    function automatic logic [LFSR_W-1:0] legal_seed(input logic [LFSR_W-1:0] s, input logic [LFSR_W-1:0] dflt);
        return (s == LOCKUP) ? dflt : s;
    endfunction
endpackage

// File: rtl/lfsr_rr_sched_arb.sv
// rr_arbiter: combinational one-hot grant to the first request at or after ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    int idx;
    always_comb begin
        grant = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lfsr_rr_sched.sv
// lfsr_rr_sched: shares one external 8-bit XNOR LFSR core among requesters, round-robin
module lfsr_rr_sched
    import lfsr_rr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STEPS = 8,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = DEF_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic [LFSR_W-1:0]   rdata,
    output logic                rvalid,
    input  logic                reseed,
    input  logic [LFSR_W-1:0]   reseed_data,
    output logic [LFSR_W-1:0]   lfsr_seed,
    output logic                lfsr_seed_en,
    output logic                lfsr_enable,
    input  logic [LFSR_W-1:0]   lfsr_rand,
    input  logic                lfsr_done,
    output logic                period_wrap
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_n;
    logic [PW-1:0]        ptr, gidx;
    logic [7:0]           cnt;
    logic                 pend, en_d;
    logic [LFSR_W-1:0]    pend_data;
    logic [NUM_REQ-1:0]   arb_grant;

    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .ptr(ptr), .grant(arb_grant));

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) gidx = PW'(i);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            SEED:    state_n = IDLE;
            IDLE:    state_n = (pend || reseed) ? SEED : (|req) ? STEP : IDLE;
            STEP:    state_n = (cnt == 8'(STEPS - 1)) ? DELIVER : STEP;
            DELIVER: state_n = IDLE;
        endcase
    end

    // Gated by rst so the core sees no control activity while held in reset
    assign lfsr_seed_en = (state == SEED) && !rst;
    assign lfsr_enable  = (state == STEP) && !rst;
    assign period_wrap  = en_d && lfsr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEED;
            grant     <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            lfsr_seed <= DEFAULT_SEED;
            ptr       <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            en_d      <= 1'b0;
        end else begin
            state  <= state_n;
            rvalid <= (state == DELIVER);
            en_d   <= lfsr_enable;
            cnt    <= (state == STEP && state_n == STEP) ? cnt + 8'd1 : 8'd0;
            if (reseed && state != IDLE) begin
                pend      <= 1'b1;
                pend_data <= reseed_data;
            end
            // A pulse arriving in IDLE is newer than any pending value
            if (state == IDLE && (pend || reseed)) begin
                lfsr_seed <= legal_seed(reseed ? reseed_data : pend_data, DEFAULT_SEED);
                pend      <= 1'b0;
            end else if (state == IDLE && (|req)) begin
                grant <= arb_grant;
            end
            if (state == DELIVER) begin
                rdata <= lfsr_rand;
                grant <= '0;
                ptr   <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule
